// File: rtl/pma_region_table.sv
// Runtime-programmable physical memory attribute table: NR_RULES lockable address ranges,
// looked up on NR_PORTS independent channels with a one-cycle registered response.
module pma_region_table #(
    parameter int unsigned NR_RULES     = 8,
    parameter int unsigned NR_PORTS     = 2,
    parameter int unsigned ADDR_W       = 56,
    parameter logic [2:0]  DEFAULT_ATTR = 3'b100,
    parameter int unsigned IDX_W        = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_req_i,
    input  logic                       cfg_we_i,
    input  logic [IDX_W-1:0]           cfg_idx_i,
    input  logic [1:0]                 cfg_field_i,
    input  logic [ADDR_W-1:0]          cfg_wdata_i,
    output logic                       cfg_rvalid_o,
    output logic [ADDR_W-1:0]          cfg_rdata_o,
    output logic                       cfg_err_o,
    input  logic [NR_PORTS-1:0]        lk_valid_i,
    input  logic [NR_PORTS*ADDR_W-1:0] lk_addr_i,
    output logic [NR_PORTS-1:0]        lk_valid_o,
    output logic [NR_PORTS-1:0]        lk_hit_o,
    output logic [NR_PORTS*IDX_W-1:0]  lk_idx_o,
    output logic [NR_PORTS*3-1:0]      lk_attr_o
);

    localparam logic [1:0] F_BASE = 2'd0;
    localparam logic [1:0] F_LEN  = 2'd1;
    localparam logic [1:0] F_ATTR = 2'd2;

    // attr_reg layout: {lock, en, nonidem, exec, cached}
    logic [ADDR_W-1:0] base_reg [NR_RULES];
    logic [ADDR_W-1:0] len_reg  [NR_RULES];
    logic [4:0]        attr_reg [NR_RULES];
    logic [ADDR_W:0]   rule_end [NR_RULES];

    logic [NR_RULES-1:0] rule_sel;
    logic [NR_RULES-1:0] wr_en;

    logic [ADDR_W-1:0] sel_base;
    logic [ADDR_W-1:0] sel_len;
    logic [4:0]        sel_attr;
    logic              idx_ok;
    logic              cfg_err;
    logic              wr_ok;
    logic [ADDR_W-1:0] rd_data;

    logic              cfg_rvalid_reg;
    logic [ADDR_W-1:0] cfg_rdata_reg;
    logic              cfg_err_reg;

    // An out-of-range index decodes to no rule at all, which is what flags it as an error.
    always_comb begin
        sel_base = '0;
        sel_len  = '0;
        sel_attr = '0;
        for (int r = 0; r < NR_RULES; r++) begin
            if (rule_sel[r]) begin
                sel_base = base_reg[r];
                sel_len  = len_reg[r];
                sel_attr = attr_reg[r];
            end
        end
    end

    always_comb begin
        idx_ok  = |rule_sel;
        cfg_err = !idx_ok || (cfg_field_i == 2'd3) || (cfg_we_i && sel_attr[4]);
        wr_ok   = cfg_req_i && cfg_we_i && !cfg_err;
        case (cfg_field_i)
            F_BASE:  rd_data = sel_base;
            F_LEN:   rd_data = sel_len;
            F_ATTR:  rd_data = ADDR_W'({sel_attr[4], 3'b000, sel_attr[3:0]});
            default: rd_data = '0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NR_RULES; gi++) begin : g_rule
            assign rule_sel[gi] = (cfg_idx_i == IDX_W'(gi));
            assign wr_en[gi]    = wr_ok && rule_sel[gi];
            // One extra bit so a range reaching the top of the address space does not wrap.
            assign rule_end[gi] = {1'b0, base_reg[gi]} + {1'b0, len_reg[gi]};

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    base_reg[gi] <= '0;
                    len_reg[gi]  <= '0;
                    attr_reg[gi] <= '0;
                end else if (wr_en[gi]) begin
                    case (cfg_field_i)
                        F_BASE:  base_reg[gi] <= cfg_wdata_i;
                        F_LEN:   len_reg[gi]  <= cfg_wdata_i;
                        F_ATTR:  attr_reg[gi] <= {cfg_wdata_i[7], cfg_wdata_i[3:0]};
                        default: ;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_rvalid_reg <= 1'b0;
            cfg_rdata_reg  <= '0;
            cfg_err_reg    <= 1'b0;
        end else begin
            cfg_rvalid_reg <= cfg_req_i;
            if (cfg_req_i) begin
                cfg_err_reg   <= cfg_err;
                cfg_rdata_reg <= (cfg_we_i || cfg_err) ? '0 : rd_data;
            end
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_reg;
    assign cfg_rdata_o  = cfg_rdata_reg;
    assign cfg_err_o    = cfg_err_reg;

    generate
        for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
            logic [ADDR_W-1:0]   addr;
            logic [NR_RULES-1:0] match;
            logic                hit_c;
            logic [IDX_W-1:0]    idx_c;
            logic [2:0]          attr_c;
            logic                valid_reg;
            logic                hit_reg;
            logic [IDX_W-1:0]    idx_reg;
            logic [2:0]          attr_reg_p;

            assign addr = lk_addr_i[gi*ADDR_W +: ADDR_W];

            for (genvar gr = 0; gr < NR_RULES; gr++) begin : g_match
                assign match[gr] = attr_reg[gr][3] && (len_reg[gr] != '0) &&
                                   (addr >= base_reg[gr]) && ({1'b0, addr} < rule_end[gr]);
            end

            // Scan from the top so the lowest matching index is the one left standing.
            always_comb begin
                hit_c  = 1'b0;
                idx_c  = '0;
                attr_c = DEFAULT_ATTR;
                for (int r = NR_RULES - 1; r >= 0; r--) begin
                    if (match[r]) begin
                        hit_c  = 1'b1;
                        idx_c  = IDX_W'(r);
                        attr_c = attr_reg[r][2:0];
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_reg  <= 1'b0;
                    hit_reg    <= 1'b0;
                    idx_reg    <= '0;
                    attr_reg_p <= '0;
                end else begin
                    valid_reg <= lk_valid_i[gi];
                    if (lk_valid_i[gi]) begin
                        hit_reg    <= hit_c;
                        idx_reg    <= idx_c;
                        attr_reg_p <= attr_c;
                    end
                end
            end

            assign lk_valid_o[gi]             = valid_reg;
            assign lk_hit_o[gi]               = hit_reg;
            assign lk_idx_o[gi*IDX_W +: IDX_W] = idx_reg;
            assign lk_attr_o[gi*3 +: 3]       = attr_reg_p;
        end
    endgenerate

endmodule

// File: tb/tb_pma_region_table.sv
// Scoreboard bench for pma_region_table: directed config/lookup vectors with hand-derived
// expectations, then random lookups checked against a small behavioural model.
module tb_pma_region_table;

    // Six rules keep a 3-bit index, so indices 6 and 7 exercise the out-of-range path.
    localparam int NR = 6;
    localparam int NP = 2;
    localparam int AW = 56;
    localparam int IW = 3;
    localparam logic [AW-1:0] TOP = {AW{1'b1}};

    logic              clk = 1'b0;
    logic              rst_i;
    logic              cfg_req, cfg_we;
    logic [IW-1:0]     cfg_idx;
    logic [1:0]        cfg_field;
    logic [AW-1:0]     cfg_wdata;
    logic              cfg_rvalid_o, cfg_err_o;
    logic [AW-1:0]     cfg_rdata_o;
    logic [NP-1:0]     lk_valid_in, lk_valid_out, lk_hit_out;
    logic [NP*AW-1:0]  lk_addr_in;
    logic [NP*IW-1:0]  lk_idx_out;
    logic [NP*3-1:0]   lk_attr_out;

    always #5 clk = ~clk;

    pma_region_table #(.NR_RULES(NR), .NR_PORTS(NP), .ADDR_W(AW), .DEFAULT_ATTR(3'b100)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
        .cfg_wdata_i(cfg_wdata), .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o),
        .cfg_err_o(cfg_err_o), .lk_valid_i(lk_valid_in), .lk_addr_i(lk_addr_in),
        .lk_valid_o(lk_valid_out), .lk_hit_o(lk_hit_out), .lk_idx_o(lk_idx_out),
        .lk_attr_o(lk_attr_out)
    );

    typedef struct { int due; logic [AW-1:0] rdata; logic err; } cfg_exp_t;
    typedef struct { int due; logic hit; logic [IW-1:0] idx; logic [2:0] attr; } lk_exp_t;

    cfg_exp_t cfg_q[$];
    lk_exp_t  lk_q[NP][$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;

    logic [AW-1:0] m_base [NR];
    logic [AW-1:0] m_len  [NR];
    logic [4:0]    m_attr [NR];

    always @(posedge clk) cycle++;

    function automatic lk_exp_t model_lk(input logic [AW-1:0] a);
        lk_exp_t e;
        logic [AW:0] lim;
        e.due = 0; e.hit = 1'b0; e.idx = '0; e.attr = 3'b100;
        for (int r = 0; r < NR; r++) begin
            lim = {1'b0, m_base[r]} + {1'b0, m_len[r]};
            if (m_attr[r][3] && m_len[r] != '0 && a >= m_base[r] && {1'b0, a} < lim) begin
                e.hit = 1'b1; e.idx = IW'(r); e.attr = m_attr[r][2:0];
                break;
            end
        end
        return e;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        logic [63:0] w;
        case ($urandom_range(0, 4))
            0:       return AW'($urandom_range(0, 'h1FFF));
            1:       return AW'(64'h4000_0000 + 64'($urandom_range(0, 'h2FF)));
            2:       return TOP - AW'($urandom_range(0, 'h1F));
            3:       begin w = {$urandom, $urandom}; return w[AW-1:0]; end
            default: return AW'(64'h5000 + 64'($urandom_range(0, 3)));
        endcase
    endfunction

    task automatic set_cfg(input logic we, input logic [IW-1:0] idx, input logic [1:0] field,
                           input logic [AW-1:0] data, input logic [AW-1:0] exp_rdata,
                           input logic exp_err);
        cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_field = field; cfg_wdata = data;
        cfg_q.push_back('{cycle + 1, exp_rdata, exp_err});
        if (we && !exp_err && int'(idx) < NR) begin
            case (field)
                2'd0:    m_base[idx] = data;
                2'd1:    m_len[idx]  = data;
                default: m_attr[idx] = {data[7], data[3:0]};
            endcase
        end
    endtask

    task automatic set_lk(input int p, input logic [AW-1:0] a, input logic hit,
                          input logic [IW-1:0] idx, input logic [2:0] attr);
        lk_valid_in[p] = 1'b1;
        lk_addr_in[p*AW +: AW] = a;
        lk_q[p].push_back('{cycle + 1, hit, idx, attr});
    endtask

    task automatic set_lk_model(input int p, input logic [AW-1:0] a);
        lk_exp_t e;
        e = model_lk(a);
        set_lk(p, a, e.hit, e.idx, e.attr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_req = 1'b0; cfg_we = 1'b0; lk_valid_in = '0;
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [1:0] field,
                      input logic [AW-1:0] data, input logic exp_err);
        set_cfg(1'b1, idx, field, data, '0, exp_err);
        tick();
    endtask

    task automatic rd(input logic [IW-1:0] idx, input logic [1:0] field,
                      input logic [AW-1:0] exp_rdata, input logic exp_err);
        set_cfg(1'b0, idx, field, '0, exp_rdata, exp_err);
        tick();
    endtask

    // Monitor: pops the scoreboard whenever a response appears, and checks hold when idle.
    cfg_exp_t ce;
    lk_exp_t  le;
    logic [NP-1:0] last_hit;
    logic [IW-1:0] last_idx  [NP];
    logic [2:0]    last_attr [NP];

    always @(negedge clk) begin
        if (rst_i) begin
            last_hit = '0;
            for (int p = 0; p < NP; p++) begin last_idx[p] = '0; last_attr[p] = '0; end
        end else begin
            if (cfg_rvalid_o) begin
                checks++;
                if (cfg_q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg_unexpected: got rvalid=1 at cycle %0d, required no response", cycle);
                end else begin
                    ce = cfg_q.pop_front();
                    if (ce.due != cycle || cfg_rdata_o !== ce.rdata || cfg_err_o !== ce.err) begin
                        errors++;
                        $display("FAIL cfg_resp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                                 cfg_rdata_o, cfg_err_o, cycle, ce.rdata, ce.err, ce.due);
                    end
                end
            end else if (cfg_q.size() > 0 && cfg_q[0].due <= cycle) begin
                checks++; errors++;
                ce = cfg_q.pop_front();
                $display("FAIL cfg_missing: got rvalid=0 at cycle %0d, required response due %0d", cycle, ce.due);
            end
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (lk_valid_out[p]) begin
                    if (lk_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL lk%0d_unexpected: got valid=1 at cycle %0d, required none", p, cycle);
                    end else begin
                        le = lk_q[p].pop_front();
                        if (le.due != cycle || lk_hit_out[p] !== le.hit ||
                            lk_idx_out[p*IW +: IW] !== le.idx || lk_attr_out[p*3 +: 3] !== le.attr) begin
                            errors++;
                            $display("FAIL lk%0d_resp: got hit=%b idx=%0d attr=%b cyc=%0d, required hit=%b idx=%0d attr=%b cyc=%0d",
                                     p, lk_hit_out[p], lk_idx_out[p*IW +: IW], lk_attr_out[p*3 +: 3], cycle,
                                     le.hit, le.idx, le.attr, le.due);
                        end
                    end
                    last_hit[p]  = lk_hit_out[p];
                    last_idx[p]  = lk_idx_out[p*IW +: IW];
                    last_attr[p] = lk_attr_out[p*3 +: 3];
                end else if (lk_q[p].size() > 0 && lk_q[p][0].due <= cycle) begin
                    errors++;
                    le = lk_q[p].pop_front();
                    $display("FAIL lk%0d_missing: got valid=0 at cycle %0d, required response due %0d", p, cycle, le.due);
                end else if (lk_hit_out[p] !== last_hit[p] || lk_idx_out[p*IW +: IW] !== last_idx[p] ||
                             lk_attr_out[p*3 +: 3] !== last_attr[p]) begin
                    errors++;
                    $display("FAIL lk%0d_hold: got hit=%b idx=%0d attr=%b, required hit=%b idx=%0d attr=%b",
                             p, lk_hit_out[p], lk_idx_out[p*IW +: IW], lk_attr_out[p*3 +: 3],
                             last_hit[p], last_idx[p], last_attr[p]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
        lk_valid_in = '0; lk_addr_in = '0;
        for (int r = 0; r < NR; r++) begin m_base[r] = '0; m_len[r] = '0; m_attr[r] = '0; end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cfg_rvalid_o, cfg_rdata_o, cfg_err_o, lk_valid_out, lk_hit_out, lk_idx_out, lk_attr_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rvalid=%b rdata=%h err=%b lkv=%b hit=%b idx=%h attr=%h, required all 0",
                     cfg_rvalid_o, cfg_rdata_o, cfg_err_o, lk_valid_out, lk_hit_out, lk_idx_out, lk_attr_out);
        end
        rst_i = 1'b0;

        // Empty table: default attributes on both ports.
        set_lk(0, 'h8000_0000, 0, 0, 3'b100); set_lk(1, 'h8000_0000, 0, 0, 3'b100); tick();

        // Rule0 covers [0x8000_0000, 0xC000_0000).
        wr(0, 0, 'h8000_0000, 0); wr(0, 1, 'h4000_0000, 0); wr(0, 2, 'h0B, 0);
        set_lk(0, 'hBFFF_FFFF, 1, 0, 3'b011); set_lk(1, 'hC000_0000, 0, 0, 3'b100); tick();
        set_lk(0, 'h7FFF_FFFF, 0, 0, 3'b100); set_lk(1, 'h8000_0000, 1, 0, 3'b011); tick();
        rd(0, 0, 'h8000_0000, 0); rd(0, 2, 'h0B, 0);

        // Overlap: rule1 beats rule3 until rule1 is disabled.
        wr(1, 0, 0, 0); wr(1, 1, 'h1_0000, 0); wr(1, 2, 'h0C, 0);
        wr(3, 0, 0, 0); wr(3, 1, 'h1000, 0);   wr(3, 2, 'h0A, 0);
        set_lk(0, 'h800, 1, 1, 3'b100); set_lk(1, 'h1800, 1, 1, 3'b100); tick();
        wr(1, 2, 'h00, 0);
        set_lk(0, 'h800, 1, 3, 3'b010); set_lk(1, 'h1800, 0, 0, 3'b100); tick();

        // Lock: a lookup alongside the locking write still sees the disabled rule.
        wr(2, 0, 'h4000_0000, 0); wr(2, 1, 'h100, 0);
        set_cfg(1, 2, 2, 'h89, 0, 0); set_lk(0, 'h4000_0010, 0, 0, 3'b100); tick();
        set_lk(0, 'h4000_0010, 1, 2, 3'b001); set_lk(1, 'h4000_0100, 0, 0, 3'b100); tick();
        wr(2, 0, 'h1234, 1); rd(2, 0, 'h4000_0000, 0); rd(2, 2, 'h89, 0);
        set_cfg(1, 2, 2, 'h00, 0, 1); set_lk(0, 'h4000_00FF, 1, 2, 3'b001); tick();
        rd(2, 3, 0, 1); wr(4, 3, 'h55, 1); rd(0, 1, 'h4000_0000, 0);

        // Top-of-space range must not wrap.
        wr(0, 0, TOP - 15, 0); wr(0, 1, 'h10, 0);
        set_lk(0, TOP, 1, 0, 3'b011); set_lk(1, 0, 1, 3, 3'b010); tick();
        set_lk(0, TOP - 16, 0, 0, 3'b100); set_lk(1, TOP - 15, 1, 0, 3'b011); tick();

        // Zero length never matches; indices 6/7 are out of range.
        wr(4, 0, 'h5000, 0); wr(4, 2, 'h0F, 0);
        set_lk(0, 'h5000, 0, 0, 3'b100); set_lk(1, 'h5000, 0, 0, 3'b100); tick();
        rd(4, 1, 0, 0); wr(6, 0, 'h1, 1); rd(7, 1, 0, 1); rd(6, 2, 0, 1);

        // Random traffic on both ports, with a reset in the middle of the stream.
        for (int i = 0; i < 100; i++) begin
            if (i == 60) begin
                set_lk_model(0, pick_addr()); set_lk_model(1, pick_addr()); tick();
                rst_i = 1'b1;
                #1;
                checks++;
                if (lk_valid_out !== '0 || cfg_rvalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_midstream: got lk_valid=%b rvalid=%b, required 0 0", lk_valid_out, cfg_rvalid_o);
                end
                cfg_q.delete();
                for (int p = 0; p < NP; p++) lk_q[p].delete();
                for (int r = 0; r < NR; r++) begin m_base[r] = '0; m_len[r] = '0; m_attr[r] = '0; end
                @(posedge clk);
                #1;
                rst_i = 1'b0;
                wr(5, 0, 'h4000_0000, 0); wr(5, 1, 'h200, 0); wr(5, 2, 'h0E, 0);
            end
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 7) != 0) set_lk_model(p, pick_addr());
            tick();
        end
        tick(); tick();

        checks++;
        if (cfg_q.size() != 0 || lk_q[0].size() != 0 || lk_q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d pending, required 0", cfg_q.size(), lk_q[0].size(), lk_q[1].size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
